// File: rtl/gf180mcu_fd_sc_mcu7t5v0_decap_seq.sv
// Staged enable/disable sequencer for switched decap banks (thermometer ramp, STEP cycles per bank).
// Define GF180MCU_DECAP_SEQ_FAST_OFF_EN to drop all banks at once on disable instead of ramping down.
module gf180mcu_fd_sc_mcu7t5v0_decap_seq #(
  parameter int NBANK = 8,
  parameter int STEP  = 16
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic             HOLD,
  output logic [NBANK-1:0] BANK_EN,
  output logic             READY,
  output logic             BUSY
);

  typedef enum logic [1:0] {OFF, UP, ON, DOWN} state_e;

  localparam logic [7:0] TLAST = 8'(STEP - 1);

  state_e           state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic [NBANK-1:0] bank_q, bank_d;
  logic             ready_q, busy_q;
  logic             step_hit;

  assign step_hit = (timer_q == TLAST);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bank_d  = bank_q;
    case (state_q)
      OFF: begin
        bank_d = '0;
        if (EN) begin
          state_d = UP;
          timer_d = '0;
        end
      end
      UP: begin
        if (!EN) begin
          timer_d = '0;
`ifdef GF180MCU_DECAP_SEQ_FAST_OFF_EN
          bank_d  = '0;
          state_d = OFF;
`else
          state_d = DOWN;
`endif
        end else if (!HOLD) begin
          if (step_hit) begin
            timer_d = '0;
            bank_d  = {bank_q[NBANK-2:0], 1'b1};
            // The change that lights the top bank completes the ramp.
            if (bank_d[NBANK-1]) state_d = ON;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
      end
      ON: begin
        timer_d = '0;
        if (!EN) begin
`ifdef GF180MCU_DECAP_SEQ_FAST_OFF_EN
          bank_d  = '0;
          state_d = OFF;
`else
          state_d = DOWN;
`endif
        end
      end
      DOWN: begin
        if (EN) begin
          state_d = UP;
          timer_d = '0;
        end else begin
`ifdef GF180MCU_DECAP_SEQ_FAST_OFF_EN
          timer_d = '0;
          bank_d  = '0;
          state_d = OFF;
`else
          if (!HOLD) begin
            if (step_hit) begin
              timer_d = '0;
              bank_d  = bank_q >> 1;
              if (bank_d == '0) state_d = OFF;
            end else begin
              timer_d = timer_q + 8'd1;
            end
          end
`endif
        end
      end
      default: begin
        state_d = OFF;
        timer_d = '0;
        bank_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= OFF;
      timer_q <= '0;
      bank_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bank_q  <= bank_d;
      ready_q <= (state_d == ON);
      busy_q  <= (state_d == UP) || (state_d == DOWN);
    end
  end

  assign BANK_EN = bank_q;
  assign READY   = ready_q;
  assign BUSY    = busy_q;

endmodule
